multicycle_ctrl_fsm: RTL

//  Parametrised multi-cycle control unit for the single-issue CPU datapath.
//  - Registered FSM with per-class state skipping: ALU ops never enter MEM; stores never enter WB.
//  - Waits on IM/DM ready handshakes; latches the instruction word on capture.
//  - Retires and counts instructions; raises done after total_ir retirements or on an all-zero word.
//  - Drives datapath enables and operand/writeback selects; sits between PC, IM, DM, regfile and ALU.

---
 rtl/multicycle_ctrl_fsm.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control unit for the single-issue CPU: sequences fetch/decode/exec/mem/wb/retire,
// waits on IM/DM ready with a timeout, and decodes operand/writeback selects from the latched word.
module multicycle_ctrl_fsm #(
  parameter int PC_W     = 10,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 64,
  parameter int IM_BASE  = 'h7F,
  parameter int WAIT_MAX = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   PC,
  input  logic [DATA_W-1:0] ir,
  input  logic              im_ready,
  input  logic              dm_ready,
  input  logic [15:0]       total_ir,
  output logic [PC_W-1:0]   im_addr,
  output logic              im_en,
  output logic              dm_en,
  output logic              dm_we,
  output logic              reg_rd_en,
  output logic              alu_en,
  output logic              reg_wr_en,
  output logic              pc_inc,
  output logic              wb_sel,
  output logic [1:0]        imm_sel,
  output logic [1:0]        alu_src1,
  output logic [1:0]        alu_src2,
  output logic [DATA_W-1:0] ir_q,
  output logic [CNT_W-1:0]  ins_cnt,
  output logic              done,
  output logic              mem_timeout
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | IM request outstanding, capture word on im_ready
  // DECODE | regfile read
  // EXEC   | ALU execute
  // MEM    | DM request outstanding (loads and stores only)
  // WB     | regfile write (skipped by stores, suppressed for NOP)
  // RETIRE | advance PC, count instruction
  // HALT   | done, held until reset
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_RETIRE, S_HALT
  } state_t;

  localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [5:0] OP_LWI  = 6'b000010;
  localparam logic [5:0] OP_SWI  = 6'b001010;
  localparam logic [5:0] OP_MEM  = 6'b011100;
  localparam logic [5:0] OP_ALU1 = 6'b100000;
  localparam logic [5:0] OP_MOVI = 6'b100010;
  localparam logic [5:0] OP_ADDI = 6'b101000;
  localparam logic [5:0] OP_XORI = 6'b101011;
  localparam logic [5:0] OP_ORI  = 6'b101100;

  state_t             state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               wait_expired;
  logic               timeout_hit;

  logic [5:0] op;
  logic [4:0] sub5;
  logic [7:0] sub8;
  logic       is_lw, is_sw, is_shift, is_load, is_store, is_nop;

  assign op   = ir_q[30:25];
  assign sub5 = ir_q[4:0];
  assign sub8 = ir_q[7:0];

  assign is_lw    = (op == OP_MEM) && (sub8 == 8'h02);
  assign is_sw    = (op == OP_MEM) && (sub8 == 8'h0A);
  assign is_shift = (op == OP_ALU1) &&
                    ((sub5 == 5'b01000) || (sub5 == 5'b01001) || (sub5 == 5'b01011));
  assign is_load  = (op == OP_LWI) || is_lw;
  assign is_store = (op == OP_SWI) || is_sw;
  // NOP is SRLI with a zero shift amount
  assign is_nop   = (op == OP_ALU1) && (sub5 == 5'b01001) && (ir_q[14:10] == 5'd0);

  assign im_addr = PC + PC_W'(IM_BASE);
  assign wb_sel  = is_load;
  assign cnt_nxt = ins_cnt + CNT_W'(1);

  // Wait timer is a down-counter loaded on every state change; zero with no ready means expired.
  assign wait_expired = (WAIT_MAX != 0) && (wait_cnt == '0);

  always_comb begin
    imm_sel  = 2'd0;
    alu_src1 = 2'd0;
    alu_src2 = 2'd0;
    if (op == OP_ADDI) begin
      imm_sel = 2'd1;
    end else if ((op == OP_ORI) || (op == OP_XORI) || (op == OP_LWI) || (op == OP_SWI)) begin
      imm_sel = 2'd2;
    end else if (op == OP_MOVI) begin
      imm_sel  = 2'd3;
      alu_src1 = 2'd1;
      alu_src2 = 2'd1;
    end else if (is_shift || is_lw || is_sw) begin
      alu_src2 = 2'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    im_en       = 1'b0;
    dm_en       = 1'b0;
    dm_we       = 1'b0;
    reg_rd_en   = 1'b0;
    alu_en      = 1'b0;
    reg_wr_en   = 1'b0;
    pc_inc      = 1'b0;
    done        = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        im_en = 1'b1;
        if (im_ready) begin
          state_nxt = (ir == '0) ? S_HALT : S_DECODE;
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_nxt   = S_HALT;
        end
      end
      S_DECODE: begin
        reg_rd_en = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_en    = 1'b1;
        state_nxt = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dm_en = 1'b1;
        dm_we = is_store;
        if (dm_ready) begin
          state_nxt = is_store ? S_RETIRE : S_WB;
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_nxt   = S_HALT;
        end
      end
      S_WB: begin
        reg_wr_en = !is_nop;
        state_nxt = S_RETIRE;
      end
      S_RETIRE: begin
        pc_inc = 1'b1;
        // total_ir of zero disables the count limit
        if ((total_ir != 16'd0) && (cnt_nxt == CNT_W'(total_ir))) state_nxt = S_HALT;
        else                                                      state_nxt = S_FETCH;
      end
      S_HALT: begin
        done = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      ir_q        <= '0;
      ins_cnt     <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_FETCH) && im_ready) ir_q <= ir;
      if (state == S_RETIRE) ins_cnt <= cnt_nxt;
      if (timeout_hit) mem_timeout <= 1'b1;
      if (state_nxt != state) wait_cnt <= WAIT_W'(WAIT_MAX);
      else if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
    end
  end

endmodule
